// File: rtl/mul_share_pkg.sv
//==============================================================================
// Module   : mul_share_pkg
// Brief    : Shared widths, result record and the signed x unsigned multiply
//            helper for the time-shared multiplier arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package mul_share_pkg;

   // Default operand / product widths
   localparam int A_W      = 32;
   localparam int B_W      = 30;
   localparam int P_W      = 32;
   // Tag width wide enough for the largest supported requester count (16)
   localparam int ID_MAX_W = 4;

   // One returned product with its requester tag
   typedef struct packed {
      logic [P_W-1:0]      data;
      logic [ID_MAX_W-1:0] id;
   } mul_share_rsp_t;

   // Signed A times unsigned B, keeping the low P_W bits. A_W equals P_W at
   // the default widths, so A needs no extension; B is zero-extended so it
   // can never be read as negative.
   function automatic logic [P_W-1:0] mul_sxu(input logic [A_W-1:0] a,
                                              input logic [B_W-1:0] b);
      logic [P_W-1:0] sa;
      logic [P_W-1:0] sb;
      sa = a;
      sb = {{(P_W-B_W){1'b0}}, b};
      return sa * sb;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mul_share_rr_pick.sv
//==============================================================================
// Module   : mul_share_rr_pick
// Brief    : Combinational round-robin picker. Searches the request vector
//            starting one past the last grant, wrapping modulo N.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mul_share_rr_pick #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] last_grant_i,
   output logic [N-1:0]   gnt_o,
   output logic [IDW-1:0] idx_o,
   output logic           any_o
);

   logic [IDW-1:0] w_cand;

   // First requester found after last_grant wins; the search ends on itself
   always_comb begin
      gnt_o  = '0;
      idx_o  = '0;
      any_o  = 1'b0;
      w_cand = '0;
      for (int k = 1; k <= N; k++) begin
         w_cand = IDW'((int'(last_grant_i) + k) % N);
         if (!any_o && req_i[w_cand]) begin
            any_o         = 1'b1;
            idx_o         = w_cand;
            gnt_o[w_cand] = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mul_share_arbiter.sv
//==============================================================================
// Module   : mul_share_arbiter
// Brief    : Round-robin arbiter time-sharing one signed x unsigned multiplier
//            among NUM_REQ requesters; registered product returned on a single
//            valid/ready channel tagged with the requester index.
//            Optional build macro MUL_SHARE_ARBITER_PIPE_EN inserts an operand
//            register stage ahead of the multiplier (2-cycle latency).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mul_share_arbiter
   import mul_share_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int A_WIDTH  = A_W,
   parameter int B_WIDTH  = B_W,
   parameter int P_WIDTH  = P_W,
   parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic                        ap_clk_i,
   input  logic                        ap_rst_i,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   input  logic [NUM_REQ*A_WIDTH-1:0]  req_a_i,
   input  logic [NUM_REQ*B_WIDTH-1:0]  req_b_i,
   output logic                        rsp_valid_o,
   input  logic                        rsp_ready_i,
   output logic [P_WIDTH-1:0]          rsp_data_o,
   output logic [ID_WIDTH-1:0]         rsp_id_o
);

   // Final (response) stage
   logic                rsp_valid_q, rsp_valid_d;
   logic [P_WIDTH-1:0]  rsp_data_q,  rsp_data_d;
   logic [ID_WIDTH-1:0] rsp_id_q,    rsp_id_d;
   logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;

   logic                w_free;
   logic                w_slot_free;
   logic                w_accept;
   logic                w_any;
   logic [NUM_REQ-1:0]  w_gnt;
   logic [ID_WIDTH-1:0] w_gidx;
   logic [A_WIDTH-1:0]  w_sel_a;
   logic [B_WIDTH-1:0]  w_sel_b;

   // Multiplier inputs: straight from the grant mux, or from stage 1
   logic                w_mul_valid;
   logic [A_WIDTH-1:0]  w_mul_a;
   logic [B_WIDTH-1:0]  w_mul_b;
   logic [ID_WIDTH-1:0] w_mul_id;
   logic [P_WIDTH-1:0]  w_prod;

   mul_share_rr_pick #(
      .N   (NUM_REQ),
      .IDW (ID_WIDTH)
   ) u_pick (
      .req_i        (req_valid_i),
      .last_grant_i (last_grant_q),
      .gnt_o        (w_gnt),
      .idx_o        (w_gidx),
      .any_o        (w_any)
   );

   // Final stage can take a new value when empty or draining this cycle
   assign w_free   = !rsp_valid_q || rsp_ready_i;
   assign w_accept = w_slot_free && w_any && !ap_rst_i;

   // Only the winner sees ready, and only when its slot can take it
   assign req_ready_o = w_accept ? w_gnt : '0;

   assign w_sel_a = req_a_i[int'(w_gidx)*A_WIDTH +: A_WIDTH];
   assign w_sel_b = req_b_i[int'(w_gidx)*B_WIDTH +: B_WIDTH];

`ifdef MUL_SHARE_ARBITER_PIPE_EN
   logic                s1_valid_q, s1_valid_d;
   logic [A_WIDTH-1:0]  s1_a_q,     s1_a_d;
   logic [B_WIDTH-1:0]  s1_b_q,     s1_b_d;
   logic [ID_WIDTH-1:0] s1_id_q,    s1_id_d;

   // Stage 1 is free when empty or moving into the final stage this cycle
   assign w_slot_free = !s1_valid_q || w_free;

   // Operand stage next-state: loads on accept, empties when it advances
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_id_d    = s1_id_q;
      if (w_slot_free) begin
         s1_valid_d = w_accept;
         if (w_accept) begin
            s1_a_d  = w_sel_a;
            s1_b_d  = w_sel_b;
            s1_id_d = w_gidx;
         end
      end
   end

   // Operand stage register
   always_ff @(posedge ap_clk_i) begin
      if (ap_rst_i) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_id_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_id_q    <= s1_id_d;
      end
   end

   assign w_mul_valid = s1_valid_q;
   assign w_mul_a     = s1_a_q;
   assign w_mul_b     = s1_b_q;
   assign w_mul_id    = s1_id_q;
`else
   assign w_slot_free = w_free;
   assign w_mul_valid = w_accept;
   assign w_mul_a     = w_sel_a;
   assign w_mul_b     = w_sel_b;
   assign w_mul_id    = w_gidx;
`endif

   // The shared helper covers the default widths; other widths use a
   // fully extended product and keep its low bits
   if (A_WIDTH == A_W && B_WIDTH == B_W && P_WIDTH == P_W) begin : g_pkg_mul
      assign w_prod = mul_sxu(w_mul_a, w_mul_b);
   end else begin : g_gen_mul
      localparam int FULL_W = A_WIDTH + B_WIDTH + 1;
      logic [FULL_W-1:0] w_ea;
      logic [FULL_W-1:0] w_eb;
      logic [FULL_W-1:0] w_full;
      assign w_ea   = {{(B_WIDTH+1){w_mul_a[A_WIDTH-1]}}, w_mul_a};
      assign w_eb   = {{(A_WIDTH+1){1'b0}}, w_mul_b};
      assign w_full = w_ea * w_eb;
      assign w_prod = w_full[P_WIDTH-1:0];
   end

   // Response stage next-state and round-robin pointer update
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_id_d     = rsp_id_q;
      last_grant_d = last_grant_q;
      if (w_free) begin
         rsp_valid_d = w_mul_valid;
         if (w_mul_valid) begin
            rsp_data_d = w_prod;
            rsp_id_d   = w_mul_id;
         end
      end
      if (w_accept) begin
         last_grant_d = w_gidx;
      end
   end

   // Response stage register; reset gives requester 0 first priority
   always_ff @(posedge ap_clk_i) begin
      if (ap_rst_i) begin
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_id_q     <= '0;
         last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_id_q     <= rsp_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_id_o    = rsp_id_q;

endmodule

`default_nettype wire
